// File: rtl/pwm_peripheral.sv
// 16-channel PWM on one shared 8-bit step counter (CLK_DIV clocks per step); out registered, 1 clk latency.
// Define PWM_SYNC_UPDATE_EN to latch duty/enables once per period (period-aligned updates).
module pwm_peripheral #(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [15:0]   out_q, out_d;
    logic          period_start_q, period_start_d;
    logic          tick;
    logic          period_load;
    logic [7:0]    duty_active;
    logic [15:0]   en_out_act;
    logic [15:0]   en_pwm_act;
    logic          pwm_level;

    assign tick        = (presc_q == PW'(CLK_DIV - 1));
    assign presc_d     = tick ? '0 : presc_q + 1'b1;
    assign cnt_d       = tick ? cnt_q + 8'd1 : cnt_q;
    // First cycle of count 0: true after every wrap and on the first cycle out of reset.
    assign period_load = (cnt_q == 8'd0) && (presc_q == '0);
    assign period_start_d = period_load;

`ifdef PWM_SYNC_UPDATE_EN
    logic [7:0]  duty_q;
    logic [15:0] en_out_q;
    logic [15:0] en_pwm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q   <= 8'd0;
            en_out_q <= 16'h0000;
            en_pwm_q <= 16'h0000;
        end else if (period_load) begin
            duty_q   <= pwm_duty_cycle;
            en_out_q <= {en_reg_out_15_8, en_reg_out_7_0};
            en_pwm_q <= {en_reg_pwm_15_8, en_reg_pwm_7_0};
        end
    end

    // Bypass the shadow on the load cycle so the new period's first output already uses it.
    assign duty_active = period_load ? pwm_duty_cycle : duty_q;
    assign en_out_act  = period_load ? {en_reg_out_15_8, en_reg_out_7_0} : en_out_q;
    assign en_pwm_act  = period_load ? {en_reg_pwm_15_8, en_reg_pwm_7_0} : en_pwm_q;
`else
    assign duty_active = pwm_duty_cycle;
    assign en_out_act  = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm_act  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
`endif

    always_comb begin
        pwm_level = (duty_active == 8'hFF) || (cnt_q < duty_active);
        out_d     = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            out_d[i] = en_out_act[i] & (~en_pwm_act[i] | pwm_level);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q        <= '0;
            cnt_q          <= 8'd0;
            out_q          <= 16'h0000;
            period_start_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: directed and random configurations checked every cycle against
// a time-based model (cycle index since reset -> step count, period boundary, output level).
module tb_pwm_peripheral;

    localparam int CLK_DIV = 13;
    localparam int PERIOD  = CLK_DIV * 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] t_en_out;
    logic [15:0] t_en_pwm;
    logic [7:0]  t_duty;
    logic [15:0] out;
    logic        period_start;

    int compared   = 0;
    int mismatched = 0;
    int k          = 0;   // cycles elapsed since the last reset edge
    int cur_cnt    = 0;   // step count during the current cycle
    int hi [16];
    logic [15:0] l_eo, l_ep;
    logic [7:0]  l_d;

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (t_en_out[7:0]),
        .en_reg_out_15_8 (t_en_out[15:8]),
        .en_reg_pwm_7_0  (t_en_pwm[7:0]),
        .en_reg_pwm_15_8 (t_en_pwm[15:8]),
        .pwm_duty_cycle  (t_duty),
        .out             (out),
        .period_start    (period_start)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_out(input logic [15:0] eo, input logic [15:0] ep,
                                              input logic [7:0] d, input int c);
        logic [15:0] r;
        logic lvl;
        lvl = (d == 8'hFF) ? 1'b1 : (c < int'(d));
        for (int i = 0; i < 16; i++) begin
            if (!eo[i])      r[i] = 1'b0;
            else if (!ep[i]) r[i] = 1'b1;
            else             r[i] = lvl;
        end
        return r;
    endfunction

    // One clock: the edge samples the current tb inputs; model and DUT compared 1 time unit later.
    task automatic step();
        logic [15:0] exp_out;
        logic        exp_ps;
        int          cprev;
        @(posedge clk);
        #1;
        if (rst) begin
            k       = 0;
            exp_out = 16'h0000;
            exp_ps  = 1'b0;
        end else begin
            k++;
            cprev  = ((k - 1) / CLK_DIV) % 256;
            exp_ps = (((k - 1) % PERIOD) == 0);
            if (exp_ps) begin
                l_eo = t_en_out;
                l_ep = t_en_pwm;
                l_d  = t_duty;
            end
`ifdef PWM_SYNC_UPDATE_EN
            exp_out = model_out(l_eo, l_ep, l_d, cprev);
`else
            exp_out = model_out(t_en_out, t_en_pwm, t_duty, cprev);
`endif
        end
        cur_cnt = (k / CLK_DIV) % 256;
        check("out", {16'h0, out}, {16'h0, exp_out});
        check("period_start", {31'h0, period_start}, {31'h0, exp_ps});
    endtask

    task automatic wait_ps();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < PERIOD + 16 && !seen; n++) begin
            step();
            if (period_start === 1'b1) seen = 1'b1;
        end
        check("wait_period_start", {31'h0, seen}, 32'd1);
    endtask

    // Counts high cycles per output bit over one full period starting at a period_start.
    task automatic run_period();
        wait_ps();
        for (int b = 0; b < 16; b++) hi[b] = int'(out[b]);
        for (int n = 1; n < PERIOD; n++) begin
            step();
            for (int b = 0; b < 16; b++) hi[b] += int'(out[b]);
        end
    endtask

    initial begin
        int h;
        int npulse;
        int last_idx;
        int hold;
        bit changed;
        bit prev_ps;

        rst      = 1'b1;
        t_en_out = 16'h0000;
        t_en_pwm = 16'h0000;
        t_duty   = 8'h00;
        l_eo     = 16'h0000;
        l_ep     = 16'h0000;
        l_d      = 8'h00;
        step();
        step();
        check("reset_out", {16'h0, out}, 32'h0);
        check("reset_ps", {31'h0, period_start}, 32'h0);
        rst = 1'b0;

        // 50% duty on every channel
        t_en_out = 16'hFFFF;
        t_en_pwm = 16'hFFFF;
        t_duty   = 8'h80;
        run_period();
        check("duty80_high_b0", hi[0], 1664);
        check("duty80_high_b15", hi[15], 1664);

        t_duty = 8'h00;
        run_period();
        check("duty00_high_b3", hi[3], 0);

        t_duty = 8'hFF;
        run_period();
        check("dutyFF_high_b0", hi[0], PERIOD);
        check("dutyFF_high_b12", hi[12], PERIOD);

        // Mixed static / PWM / disabled channels
        t_en_out = 16'h00F0;
        t_en_pwm = 16'h0030;
        t_duty   = 8'h40;
        run_period();
        check("mixed_static_b7", hi[7], PERIOD);
        check("mixed_static_b6", hi[6], PERIOD);
        check("mixed_pwm_b5", hi[5], 832);
        check("mixed_pwm_b4", hi[4], 832);
        check("mixed_off_b0", hi[0], 0);
        check("mixed_off_b8", hi[8], 0);

        // Duty change mid-period at step 100
        t_en_out = 16'hFFFF;
        t_en_pwm = 16'hFFFF;
        t_duty   = 8'h40;
        wait_ps();
        h       = int'(out[0]);
        changed = 1'b0;
        for (int n = 1; n < PERIOD; n++) begin
            if (!changed && cur_cnt == 100) begin
                t_duty  = 8'hC0;
                changed = 1'b1;
                step();
`ifdef PWM_SYNC_UPDATE_EN
                check("change_held", {31'h0, out[0]}, 32'd0);
`else
                check("change_direct", {31'h0, out[0]}, 32'd1);
`endif
            end else begin
                step();
            end
            h += int'(out[0]);
        end
`ifdef PWM_SYNC_UPDATE_EN
        check("change_period_high", h, 832);
`else
        check("change_period_high", h, 2028);
`endif
        run_period();
        check("after_change_high", hi[0], 2496);

        // Reset pulse at step 150, then first-tick timing with duty 1
        t_duty = 8'h01;
        for (int n = 0; n < PERIOD + 16 && cur_cnt != 150; n++) step();
        rst = 1'b1;
        step();
        check("midrst_out", {16'h0, out}, 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_ps", {31'h0, period_start}, 32'd1);
        h = int'(out[0]);
        for (int n = 0; n < 19; n++) begin
            step();
            h += int'(out[0]);
        end
        check("post_rst_first_tick", h, 13);

        // period_start spacing over three periods
        wait_ps();
        npulse   = 0;
        last_idx = 0;
        prev_ps  = 1'b1;
        for (int n = 1; n <= 3 * PERIOD; n++) begin
            step();
            if (period_start === 1'b1) begin
                npulse++;
                check("ps_gap", n - last_idx, PERIOD);
                check("ps_not_back_to_back", {31'h0, prev_ps}, 32'd0);
                last_idx = n;
            end
            prev_ps = period_start;
        end
        check("ps_count", npulse, 3);

        // Random configurations held for random durations, including mid-period changes
        for (int r = 0; r < 8; r++) begin
            t_en_out = 16'($urandom);
            t_en_pwm = 16'($urandom);
            if (r == 0)      t_duty = 8'h00;
            else if (r == 1) t_duty = 8'hFF;
            else             t_duty = 8'($urandom_range(0, 255));
            if (r == 4) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            hold = int'($urandom_range(50, 800));
            repeat (hold) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
